// File: rtl/data_memory_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | data_memory_responder                                                      |
// | Byte-addressable big-endian data memory answering MOV/RW/TYPE requests     |
// | with a programmable wait and a 4-phase MFC handshake.                      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module data_memory_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              MOV,
    input  logic              RW,
    input  logic [1:0]        TYPE,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [31:0]       DATA_IN,
    output logic [31:0]       DATA_OUT,
    output logic              MFC,
    output logic              ERR
);

    localparam int         DEPTH     = 2 ** ADDR_W;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
    localparam logic [1:0] TYPE_BYTE = 2'b00;
    localparam logic [1:0] TYPE_HALF = 2'b01;
    localparam logic [1:0] TYPE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        wait_cnt;
    logic [3:0]        wait_cnt_nxt;
    logic              capture;
    logic              commit;

    logic [ADDR_W-1:0] req_addr;
    logic              req_rw;
    logic [1:0]        req_type;
    logic [31:0]       req_data;

    logic              in_idle;
    logic [ADDR_W-1:0] acc_addr;
    logic [ADDR_W-1:0] addr_p1;
    logic [ADDR_W-1:0] addr_p2;
    logic [ADDR_W-1:0] addr_p3;
    logic              acc_rw;
    logic [1:0]        acc_type;
    logic [31:0]       acc_data;
    logic              fault;
    logic              mem_we;
    logic [31:0]       rd_val;

    logic [7:0]        mem [DEPTH];

    // A zero-wait request commits on its capture edge, so the access must
    // see the live inputs while IDLE and the captured copy afterwards.
    assign in_idle  = (state == ST_IDLE);
    assign acc_addr = in_idle ? ADDR    : req_addr;
    assign acc_rw   = in_idle ? RW      : req_rw;
    assign acc_type = in_idle ? TYPE    : req_type;
    assign acc_data = in_idle ? DATA_IN : req_data;

    assign addr_p1 = acc_addr + ADDR_W'(1);
    assign addr_p2 = acc_addr + ADDR_W'(2);
    assign addr_p3 = acc_addr + ADDR_W'(3);

    always_comb begin
        fault = 1'b0;
        case (acc_type)
            TYPE_BYTE: fault = 1'b0;
            TYPE_HALF: fault = acc_addr[0];
            TYPE_WORD: fault = (acc_addr[1:0] != 2'b00);
            default:   fault = 1'b1;
        endcase
    end

    always_comb begin
        rd_val = 32'h0;
        case (acc_type)
            TYPE_BYTE: rd_val = {24'h0, mem[acc_addr]};
            TYPE_HALF: rd_val = {16'h0, mem[acc_addr], mem[addr_p1]};
            TYPE_WORD: rd_val = {mem[acc_addr], mem[addr_p1], mem[addr_p2], mem[addr_p3]};
            default:   rd_val = 32'h0;
        endcase
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        capture      = 1'b0;
        commit       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (MOV) begin
                    capture      = 1'b1;
                    wait_cnt_nxt = WAIT_INIT;
                    if (WAIT_INIT == 4'd0) begin
                        commit    = 1'b1;
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                wait_cnt_nxt = wait_cnt - 4'd1;
                if (wait_cnt <= 4'd1) begin
                    commit       = 1'b1;
                    wait_cnt_nxt = 4'd0;
                    state_nxt    = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!MOV) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
            req_addr <= '0;
            req_rw   <= 1'b0;
            req_type <= 2'b00;
            req_data <= 32'h0;
            DATA_OUT <= 32'h0;
            ERR      <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (capture) begin
                req_addr <= ADDR;
                req_rw   <= RW;
                req_type <= TYPE;
                req_data <= DATA_IN;
            end
            if (commit) begin
                ERR      <= fault;
                DATA_OUT <= (!fault && acc_rw) ? rd_val : 32'h0;
            end
        end
    end

    // Storage is deliberately outside the reset domain; CLR must never touch it.
    assign mem_we = commit && !fault && !acc_rw && !CLR;

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            case (acc_type)
                TYPE_BYTE: begin
                    mem[acc_addr] <= acc_data[7:0];
                end
                TYPE_HALF: begin
                    mem[acc_addr] <= acc_data[15:8];
                    mem[addr_p1]  <= acc_data[7:0];
                end
                TYPE_WORD: begin
                    mem[acc_addr] <= acc_data[31:24];
                    mem[addr_p1]  <= acc_data[23:16];
                    mem[addr_p2]  <= acc_data[15:8];
                    mem[addr_p3]  <= acc_data[7:0];
                end
                default: begin
                end
            endcase
        end
    end

    assign MFC = (state == ST_DONE);

endmodule
`default_nettype wire
